// File: rtl/seg7_pkg.sv
// Shared types, segment codes and sizing helpers for the BCD 7-segment driver.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        SEL_DIGIT,
        SEL_BLANK,
        SEL_MINUS
    } seg_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FORMAT
    } state_e;

    // Decimal digits needed to hold any WIDTH-bit unsigned value.
    function automatic int unsigned idig(input int unsigned width);
        return (width * 3) / 10 + 1;
    endfunction

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational 7-segment encoder for one digit: decimal glyph, blank or minus.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    input  seg_sel_e   sel_i,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (sel_i)
            SEL_DIGIT: seg_c = seg_digit(digit_i);
            SEL_MINUS: seg_c = SEG_MINUS;
            default:   seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_seg_driver.sv
// Iterative double-dabble binary-to-BCD converter driving a bank of 7-segment digits.
// Holds the last formatted result on the outputs while the next conversion runs.
module bcd_seg_driver
    import seg7_pkg::*;
#(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned SIGNED_EN = 0,
    parameter int unsigned BLANK_LZ  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_signed,
    output logic                  busy,
    output logic                  out_valid,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [8*DIGITS-1:0]   hex_out
);

    localparam int unsigned IDIG = idig(WIDTH);
    localparam int unsigned NDIG = (IDIG > DIGITS) ? IDIG : DIGITS;
    localparam int unsigned NB   = 4 * NDIG;
    localparam int unsigned CW   = $clog2(WIDTH + 1);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [NB-1:0]         bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;
    logic [4*DIGITS-1:0]   bcd_out_q, bcd_out_d;
    logic [8*DIGITS-1:0]   hex_out_q, hex_out_d;

    logic                  in_neg;
    logic [WIDTH-1:0]      in_mag;
    logic [NB-1:0]         adj;
    logic [NB+WIDTH-1:0]   shv;
    logic                  fmt_ovf;
    logic [4*DIGITS-1:0]   fmt_bcd;
    logic [8*DIGITS-1:0]   fmt_hex;
    logic [3:0]            fmt_dig [DIGITS];
    seg_sel_e              fmt_sel [DIGITS];
    int                    msd;

    // Most-negative input wraps to itself, which is still the correct unsigned magnitude.
    assign in_neg = (SIGNED_EN != 0) && in_signed && in_data[WIDTH-1];
    assign in_mag = in_neg ? (~in_data) + WIDTH'(1) : in_data;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shv = {adj, bin_q} << 1;

    // Overflow, leading-zero blanking and sign placement from the finished BCD value.
    always_comb begin
        msd     = 0;
        fmt_ovf = 1'b0;
        fmt_bcd = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        for (int i = int'(DIGITS); i < int'(NDIG); i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                fmt_ovf = 1'b1;
            end
        end
        if (neg_q && (bcd_q[4*(DIGITS-1) +: 4] != 4'd0)) begin
            fmt_ovf = 1'b1;
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            fmt_dig[i]       = bcd_q[4*i +: 4];
            fmt_bcd[4*i +: 4] = fmt_ovf ? 4'hF : bcd_q[4*i +: 4];
            if (fmt_ovf) begin
                fmt_sel[i] = SEL_MINUS;
            end else if (BLANK_LZ != 0) begin
                if (i <= msd)                      fmt_sel[i] = SEL_DIGIT;
                else if (neg_q && (i == msd + 1))  fmt_sel[i] = SEL_MINUS;
                else                               fmt_sel[i] = SEL_BLANK;
            end else begin
                if (neg_q && (i == int'(DIGITS) - 1)) fmt_sel[i] = SEL_MINUS;
                else                                  fmt_sel[i] = SEL_DIGIT;
            end
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_enc
        seg7_encode u_enc (
            .digit_i (fmt_dig[g]),
            .sel_i   (fmt_sel[g]),
            .seg_c   (fmt_hex[8*g +: 8])
        );
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;
        bcd_out_d   = bcd_out_q;
        hex_out_d   = hex_out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    bin_d      = in_mag;
                    bcd_d      = '0;
                    neg_d      = in_neg;
                    cnt_d      = CW'(WIDTH);
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = shv[NB+WIDTH-1:WIDTH];
                bin_d = shv[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FORMAT;
                end
            end
            ST_FORMAT: begin
                bcd_out_d   = fmt_bcd;
                hex_out_d   = fmt_hex;
                ovf_d       = fmt_ovf;
                out_valid_d = 1'b1;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            bcd_out_q   <= '0;
            hex_out_q   <= {DIGITS{SEG_BLANK}};
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            bcd_out_q   <= bcd_out_d;
            hex_out_q   <= hex_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign overflow  = ovf_q;
    assign bcd_out   = bcd_out_q;
    assign hex_out   = hex_out_q;

endmodule
